// File: rtl/reg_trace_checker.sv
// reg_trace_checker: steps through a loadable expected-value table, compares NUM_CH observed buses
// once per cycle, counts mismatches and records the first failing step. `TRACE_MASK_EN adds a don't-care mask table.

module reg_trace_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] obs,
    input  logic [DATA_WIDTH-1:0] exp_val,
    input  logic [DATA_WIDTH-1:0] mask,
    output logic                  miss
);
    assign miss = |((obs ^ exp_val) & mask);
endmodule

module reg_trace_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int DEPTH      = 16,
    parameter int STEP_W     = 4,
    parameter int CNT_W      = 8,
    parameter int DELAY      = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         Clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [STEP_W:0]              num_steps,
    input  logic [NUM_CH*DATA_WIDTH-1:0] obs_data,
    input  logic                         exp_wr_en,
    input  logic [STEP_W-1:0]            exp_wr_step,
    input  logic [CH_W-1:0]              exp_wr_ch,
    input  logic [DATA_WIDTH-1:0]        exp_wr_data,
`ifdef TRACE_MASK_EN
    input  logic [DATA_WIDTH-1:0]        exp_wr_mask,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [CNT_W-1:0]             mismatch_count,
    output logic [STEP_W-1:0]            first_fail_step,
    output logic [CH_W-1:0]              first_fail_ch,
    output logic                         fail_seen
);
    localparam int SUM_W = CNT_W + CH_W + 1;
    localparam logic [STEP_W:0]  DEPTH_L  = (STEP_W+1)'(DEPTH);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [7:0]       DLY_LAST = 8'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // Bit 1 = busy, bit 2 = done, so both leave the state flops without decode.
    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_WAIT = 3'b010,
        S_RUN  = 3'b011,
        S_DONE = 3'b100
    } state_t;

    state_t                           state, state_nxt;
    logic [STEP_W-1:0]                step, step_nxt;
    logic [7:0]                       dly_cnt, dly_nxt;
    logic [STEP_W:0]                  run_len, len_nxt, n_eff;
    logic [CNT_W-1:0]                 cnt_nxt, cnt_sat;
    logic                             fail_nxt, pass_nxt;
    logic [STEP_W-1:0]                ffs_nxt;
    logic [CH_W-1:0]                  ffc_nxt, first_ch;
    logic [CH_W:0]                    inc;
    logic [SUM_W-1:0]                 sum;
    logic [NUM_CH-1:0]                miss;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] rd_exp, rd_mask;
    logic                             wr_ok;

    // Expected table is deliberately left out of reset so a loaded trace survives a reset.
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] exp_mem [DEPTH];

    assign wr_ok = exp_wr_en && ({1'b0, exp_wr_step} < DEPTH_L) && ({1'b0, exp_wr_ch} < NUM_CH_L);

    always_ff @(posedge Clock) begin
        if (wr_ok) exp_mem[exp_wr_step][exp_wr_ch] <= exp_wr_data;
    end

    assign rd_exp = exp_mem[step];

`ifdef TRACE_MASK_EN
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] mask_mem [DEPTH];

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mask_mem[i] <= '1;
        end else if (wr_ok) begin
            mask_mem[exp_wr_step][exp_wr_ch] <= exp_wr_mask;
        end
    end

    assign rd_mask = mask_mem[step];
`else
    assign rd_mask = '1;
`endif

    reg_trace_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane [NUM_CH-1:0] (
        .obs     (obs_data),
        .exp_val (rd_exp),
        .mask    (rd_mask),
        .miss    (miss)
    );

    // Walk high-to-low so the lowest mismatching channel is the one left in first_ch.
    always_comb begin
        inc      = '0;
        first_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            inc = inc + (CH_W+1)'(miss[c]);
            if (miss[c]) first_ch = CH_W'(c);
        end
    end

    assign sum     = SUM_W'(mismatch_count) + SUM_W'(inc);
    assign cnt_sat = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
    assign n_eff   = (num_steps > DEPTH_L) ? DEPTH_L : num_steps;

    always_comb begin
        state_nxt = state;
        step_nxt  = step;
        dly_nxt   = dly_cnt;
        len_nxt   = run_len;
        cnt_nxt   = mismatch_count;
        fail_nxt  = fail_seen;
        ffs_nxt   = first_fail_step;
        ffc_nxt   = first_fail_ch;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    step_nxt = '0;
                    dly_nxt  = '0;
                    cnt_nxt  = '0;
                    fail_nxt = 1'b0;
                    ffs_nxt  = '0;
                    ffc_nxt  = '0;
                    len_nxt  = n_eff;
                    if (n_eff == '0)    state_nxt = S_DONE;
                    else if (DELAY > 0) state_nxt = S_WAIT;
                    else                state_nxt = S_RUN;
                end
            end
            S_WAIT: begin
                if (dly_cnt == DLY_LAST) state_nxt = S_RUN;
                else                     dly_nxt   = dly_cnt + 8'd1;
            end
            S_RUN: begin
                step_nxt = step + STEP_W'(1);
                if (inc != '0) begin
                    cnt_nxt = cnt_sat;
                    if (!fail_seen) begin
                        fail_nxt = 1'b1;
                        ffs_nxt  = step;
                        ffc_nxt  = first_ch;
                    end
                end
                if ({1'b0, step} == run_len - (STEP_W+1)'(1)) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // pass is registered from next-state values so it is a clean flop output.
    assign pass_nxt = (state_nxt == S_DONE) && (cnt_nxt == '0);

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            step            <= '0;
            dly_cnt         <= '0;
            run_len         <= '0;
            mismatch_count  <= '0;
            fail_seen       <= 1'b0;
            first_fail_step <= '0;
            first_fail_ch   <= '0;
            pass            <= 1'b0;
        end else begin
            state           <= state_nxt;
            step            <= step_nxt;
            dly_cnt         <= dly_nxt;
            run_len         <= len_nxt;
            mismatch_count  <= cnt_nxt;
            fail_seen       <= fail_nxt;
            first_fail_step <= ffs_nxt;
            first_fail_ch   <= ffc_nxt;
            pass            <= pass_nxt;
        end
    end

    assign busy = state[1];
    assign done = state[2];

endmodule

// File: doc/reg_trace_checker.md
Name: reg_trace_checker

Overview:
- Synthesizable, parametrised self-checker for the single-cycle computer.
- Samples NUM_CH observed buses each cycle and compares them against a loadable expected-value table.
  - Typical buses: register outputs and the flag word.
- Counts mismatches and records the first failing step.
- Sits beside single_cycle_computer_all, in a bench or on an FPGA debug build, and replaces manual waveform inspection.

Parameters:
- DATA_WIDTH, 32, width of each observed channel
- NUM_CH, 3, number of observed channels (e.g. RegisterOut_0, RegisterOut_1, FLAG_OUT)
- DEPTH, 16, number of expected steps stored per channel
- STEP_W, 4, step index width; must satisfy 2**STEP_W >= DEPTH
- CNT_W, 8, mismatch counter width
- DELAY, 0, cycles to wait after start before the first compare (0..255)

Ports:
- Clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse; begins a check run
- num_steps  in  STEP_W+1  steps to check this run; values above DEPTH clamp to DEPTH
- obs_data  in  NUM_CH*DATA_WIDTH  observed buses; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- exp_wr_en  in  1  expected-table write strobe
- exp_wr_step  in  STEP_W  table row to write
- exp_wr_ch  in  $clog2(NUM_CH) min 1  table channel to write
- exp_wr_data  in  DATA_WIDTH  expected value
- busy  out  1  high in WAIT or RUN
- done  out  1  high in DONE
- pass  out  1  done && mismatch_count==0
- mismatch_count  out  CNT_W  saturating count of mismatching (step, channel) pairs
- first_fail_step  out  STEP_W  step of the first mismatch
- first_fail_ch  out  $clog2(NUM_CH) min 1  lowest mismatching channel at first_fail_step
- fail_seen  out  1  high once any mismatch is recorded in the current run

Behaviour:
- Reset (async, active-high) clears all outputs and counters to 0 and returns the FSM to IDLE. The expected table is not cleared.
- Reset mid-run aborts the run immediately, with no partial result held.
- FSM:
  - IDLE: start=1 -> WAIT if DELAY>0, else RUN. Entry clears mismatch_count, fail_seen, first_fail_*, step and the delay counter.
  - WAIT: delay counter counts to DELAY-1, then -> RUN.
  - RUN: one compare per rising edge at index step, then step++. After comparing step num_steps-1 -> DONE.
  - DONE: holds all results; start=1 restarts exactly as from IDLE.
- num_steps==0: start -> DONE on the next edge with pass=1, skipping WAIT.
- start while in WAIT or RUN is ignored.
- Compare rules:
  - Each channel c of obs_data is compared combinationally with exp[step][c]; the result is registered on the same edge.
  - Per-edge increment = number of mismatching channels. mismatch_count saturates at 2**CNT_W-1 and never wraps.
  - first_fail_step and first_fail_ch are written only on the first mismatching edge of a run, when fail_seen is 0; lowest channel index wins.
- Latency: results of step s are visible one cycle after the edge that sampled step s. done rises on the cycle after the last compare edge.
- Table writes:
  - Synchronous on exp_wr_en, allowed in any state.
  - A write to the row/channel being compared on the same edge is read-before-write: the old value is used for the compare.
  - exp_wr_step >= DEPTH or exp_wr_ch >= NUM_CH: the write is dropped.
- The outputs busy, done and pass come directly from the state register and are glitch-free.

Optional Feature:
- Macro TRACE_MASK_EN.
- Defined:
  - Adds port exp_wr_mask (in, DATA_WIDTH), written alongside exp_wr_data into a parallel mask table.
  - Compare becomes ((obs ^ exp) & mask) != 0; mask bits = 0 are don't-care.
  - Mask table resets to all-ones.
- Undefined: no mask port or storage; full-width exact compare.

Test Plan:
- Load 4 steps x 3 ch with values matching a driven obs sequence; num_steps=4, DELAY=0, start -> done on the 5th cycle after start, pass=1, mismatch_count=0.
- Same table, with obs ch1 at step 2 driven 0x00000005 instead of 0x00000004 -> mismatch_count=1, first_fail_step=2, first_fail_ch=1, fail_seen=1, pass=0.
- Mismatch on ch0 and ch2 at step 1, then ch1 at step 3 -> mismatch_count=3, first_fail_step=1, first_fail_ch=0.
- CNT_W=2, all compares wrong over 4 steps x 3 ch -> mismatch_count holds 3 (saturated).
- reset pulse asserted in RUN at step 2 -> busy/done/mismatch_count go to 0 without waiting for an edge. A new start with num_steps=0 -> done=1, pass=1 one cycle later.
- With TRACE_MASK_EN: mask 0x0000FFFF, exp 0x00001234, obs 0xABCD1234 -> no mismatch. obs 0xABCD1235 -> mismatch_count=1.
